// File: rtl/shift8_pkg.sv
// Shared types and widths for the shift8 delay-line controller.
package shift8_pkg;

  localparam int DATA_W_DEFAULT = 8;
  localparam int DELAY_W        = 2;
  localparam int STALL_CNT_W    = 16;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/shift8_valid_track.sv
// Valid shadow of the three delay-line stages; picks the bit
// that lines up with the selected tap.
module shift8_valid_track
  import shift8_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [DELAY_W-1:0] sel,
  output logic               valid_at_tap
);

  logic [2:0] v;

  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
    end else begin
      v <= {v[1:0], push};
    end
  end

  always_comb begin
    valid_at_tap = 1'b0;
    unique case (1'b1)
      (sel == 2'd0): valid_at_tap = push;
      (sel == 2'd1): valid_at_tap = v[0];
      (sel == 2'd2): valid_at_tap = v[1];
      (sel == 2'd3): valid_at_tap = v[2];
      default:       valid_at_tap = 1'b0;
    endcase
  end

endmodule

// File: rtl/shift8_ctrl.sv
// Stream controller for the 4-tap delay line with drained delay changes.
// SHIFT8_CTRL_STALL_CNT_EN adds the saturating stall_cnt output.
module shift8_ctrl
  import shift8_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               in_ready,
  input  logic               cfg_valid,
  input  logic [DELAY_W-1:0] cfg_delay,
  output logic               cfg_ready,
  output logic [DATA_W-1:0]  dl_d,
  output logic [DELAY_W-1:0] dl_sel,
  input  logic [DATA_W-1:0]  dl_q,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic               busy
`ifdef SHIFT8_CTRL_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  state_t             state, state_n;
  logic [DELAY_W-1:0] sel_q, sel_n;
  logic [DELAY_W-1:0] nd_q, nd_n;
  logic [DELAY_W-1:0] cnt_q, cnt_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      sel_q <= '0;
      nd_q  <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_n;
      sel_q <= sel_n;
      nd_q  <= nd_n;
      cnt_q <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    sel_n     = sel_q;
    nd_n      = nd_q;
    cnt_n     = cnt_q;
    in_ready  = 1'b0;
    cfg_ready = 1'b0;
    busy      = 1'b0;
    unique case (state)
      RUN: begin
        in_ready  = 1'b1;
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          nd_n  = cfg_delay;
          cnt_n = sel_q;
          // nothing in flight at tap 0, switch at once
          if (sel_q == '0) begin
            sel_n = cfg_delay;
          end else begin
            state_n = DRAIN;
          end
        end
      end
      DRAIN: begin
        busy  = 1'b1;
        cnt_n = cnt_q - 2'd1;
        if (cnt_q == 2'd1) begin
          state_n = RUN;
          sel_n   = nd_q;
        end
      end
      default: state_n = RUN;
    endcase
  end

  shift8_valid_track u_track (
    .clk          (clk),
    .rst          (rst),
    .push         (in_valid & in_ready),
    .sel          (sel_q),
    .valid_at_tap (out_valid)
  );

  assign dl_d     = in_data;
  assign dl_sel   = sel_q;
  assign out_data = dl_q;

`ifdef SHIFT8_CTRL_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (in_valid && !in_ready && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_shift8_ctrl.sv
// Directed vector bench for shift8_ctrl with a behavioural delay line.
module tb_shift8_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       cfg_valid;
  logic [1:0] cfg_delay;
  logic       cfg_ready;
  logic [7:0] dl_d;
  logic [1:0] dl_sel;
  logic [7:0] dl_q;
  logic       out_valid;
  logic [7:0] out_data;
  logic       busy;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift8_ctrl #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .cfg_valid (cfg_valid),
    .cfg_delay (cfg_delay),
    .cfg_ready (cfg_ready),
    .dl_d      (dl_d),
    .dl_sel    (dl_sel),
    .dl_q      (dl_q),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy)
`ifdef SHIFT8_CTRL_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

`ifndef SHIFT8_CTRL_STALL_CNT_EN
  assign stall_cnt = '0;
`endif

  // free-running delay line sitting beside the controller
  logic [7:0] s1 = '0, s2 = '0, s3 = '0;
  always_ff @(posedge clk) begin
    s1 <= dl_d;
    s2 <= s1;
    s3 <= s2;
  end
  always_comb begin
    dl_q = in_data;
    case (dl_sel)
      2'd0: dl_q = dl_d;
      2'd1: dl_q = s1;
      2'd2: dl_q = s2;
      default: dl_q = s3;
    endcase
  end

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       cv;
    logic [1:0] cd;
    logic       rs;
    logic       rdy;
    logic       cr;
    logic       ov;
    logic [7:0] od;
    logic [1:0] sel;
    logic       bsy;
    logic [15:0] st;
  } vec_t;

  vec_t vq[$];

  function automatic void add(
    input logic iv, input logic [7:0] d,
    input logic cv, input logic [1:0] cd,
    input logic rs, input logic rdy, input logic cr,
    input logic ov, input logic [7:0] od,
    input logic [1:0] sel, input logic bsy,
    input logic [15:0] st);
    vec_t v;
    v.iv = iv; v.d = d; v.cv = cv; v.cd = cd; v.rs = rs;
    v.rdy = rdy; v.cr = cr; v.ov = ov; v.od = od;
    v.sel = sel; v.bsy = bsy; v.st = st;
    vq.push_back(v);
  endfunction

  task automatic chk(input string nm, input int cyc,
                     input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h",
               nm, cyc, act, exp);
    end
  endtask

  initial begin
    int n;
    // reset state, then delay 0 streaming
    add(0, 8'h00, 0, 0, 0, 1, 1, 0, 8'h00, 0, 0, 0);
    for (int i = 1; i <= 8; i++)
      add(1, 8'(i), 0, 0, 0, 1, 1, 1, 8'(i), 0, 0, 0);
    for (int i = 0; i < 3; i++)
      add(0, 8'h00, 0, 0, 0, 1, 1, 0, 8'h00, 0, 0, 0);
    // 0 -> 3 without drain
    add(0, 8'h00, 1, 3, 0, 1, 1, 0, 8'h00, 0, 0, 0);
    add(1, 8'hA0, 0, 0, 0, 1, 1, 0, 8'h00, 3, 0, 0);
    add(1, 8'hA1, 0, 0, 0, 1, 1, 0, 8'h00, 3, 0, 0);
    add(1, 8'hA2, 0, 0, 0, 1, 1, 0, 8'h00, 3, 0, 0);
    add(1, 8'hA3, 0, 0, 0, 1, 1, 1, 8'hA0, 3, 0, 0);
    add(0, 8'h00, 0, 0, 0, 1, 1, 1, 8'hA1, 3, 0, 0);
    add(0, 8'h00, 0, 0, 0, 1, 1, 1, 8'hA2, 3, 0, 0);
    add(0, 8'h00, 0, 0, 0, 1, 1, 1, 8'hA3, 3, 0, 0);
    add(0, 8'h00, 0, 0, 0, 1, 1, 0, 8'h00, 3, 0, 0);
    // 3 -> 1 with sample 0x5A in the same cycle
    add(1, 8'h5A, 1, 1, 0, 1, 1, 0, 8'h00, 3, 0, 0);
    add(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 3, 1, 0);
    add(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 3, 1, 0);
    add(0, 8'h00, 0, 0, 0, 0, 0, 1, 8'h5A, 3, 1, 0);
    add(0, 8'h00, 0, 0, 0, 1, 1, 0, 8'h00, 1, 0, 0);
    // 1 -> 2
    add(0, 8'h00, 1, 2, 0, 1, 1, 0, 8'h00, 1, 0, 0);
    add(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 1, 1, 0);
    add(0, 8'h00, 0, 0, 0, 1, 1, 0, 8'h00, 2, 0, 0);
    // 2 -> 0 with in_valid held through the drain
    add(1, 8'hB0, 0, 0, 0, 1, 1, 0, 8'h00, 2, 0, 0);
    add(1, 8'hB1, 1, 0, 0, 1, 1, 0, 8'h00, 2, 0, 0);
    add(1, 8'hB2, 0, 0, 0, 0, 0, 1, 8'hB0, 2, 1, 0);
    add(1, 8'hB2, 0, 0, 0, 0, 0, 1, 8'hB1, 2, 1, 1);
    add(1, 8'hB2, 0, 0, 0, 1, 1, 1, 8'hB2, 0, 0, 2);
    add(1, 8'hB3, 0, 0, 0, 1, 1, 1, 8'hB3, 0, 0, 2);
    for (int i = 0; i < 3; i++)
      add(0, 8'h00, 0, 0, 0, 1, 1, 0, 8'h00, 0, 0, 2);
    // 0 -> 3, then reset in the middle of a 3 -> 1 drain
    add(0, 8'h00, 1, 3, 0, 1, 1, 0, 8'h00, 0, 0, 2);
    add(1, 8'hD0, 0, 0, 0, 1, 1, 0, 8'h00, 3, 0, 2);
    add(1, 8'hD1, 0, 0, 0, 1, 1, 0, 8'h00, 3, 0, 2);
    add(1, 8'hD2, 1, 1, 0, 1, 1, 0, 8'h00, 3, 0, 2);
    add(0, 8'h00, 0, 0, 1, 0, 0, 1, 8'hD0, 3, 1, 2);
    add(0, 8'h00, 0, 0, 0, 1, 1, 0, 8'h00, 0, 0, 0);
    add(0, 8'h00, 0, 0, 0, 1, 1, 0, 8'h00, 0, 0, 0);
    // 0 -> 2, then 2 -> 2 still drains
    add(0, 8'h00, 1, 2, 0, 1, 1, 0, 8'h00, 0, 0, 0);
    add(1, 8'hE0, 0, 0, 0, 1, 1, 0, 8'h00, 2, 0, 0);
    add(0, 8'h00, 1, 2, 0, 1, 1, 0, 8'h00, 2, 0, 0);
    add(0, 8'h00, 0, 0, 0, 0, 0, 1, 8'hE0, 2, 1, 0);
    add(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 2, 1, 0);
    add(0, 8'h00, 0, 0, 0, 1, 1, 0, 8'h00, 2, 0, 0);
    add(1, 8'hE1, 0, 0, 0, 1, 1, 0, 8'h00, 2, 0, 0);
    add(0, 8'h00, 0, 0, 0, 1, 1, 0, 8'h00, 2, 0, 0);
    add(0, 8'h00, 0, 0, 0, 1, 1, 1, 8'hE1, 2, 0, 0);
    add(0, 8'h00, 0, 0, 0, 1, 1, 0, 8'h00, 2, 0, 0);

    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    cfg_valid = 1'b0; cfg_delay = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < vq.size(); k++) begin
      @(negedge clk);
      in_valid  = vq[k].iv;
      in_data   = vq[k].d;
      cfg_valid = vq[k].cv;
      cfg_delay = vq[k].cd;
      rst       = vq[k].rs;
      #1;
      chk("in_ready", k, 16'(in_ready), 16'(vq[k].rdy));
      chk("cfg_ready", k, 16'(cfg_ready), 16'(vq[k].cr));
      chk("out_valid", k, 16'(out_valid), 16'(vq[k].ov));
      chk("dl_sel", k, 16'(dl_sel), 16'(vq[k].sel));
      chk("busy", k, 16'(busy), 16'(vq[k].bsy));
      chk("dl_d", k, 16'(dl_d), 16'(vq[k].d));
      if (vq[k].ov)
        chk("out_data", k, 16'(out_data), 16'(vq[k].od));
`ifdef SHIFT8_CTRL_STALL_CNT_EN
      chk("stall_cnt", k, stall_cnt, vq[k].st);
`endif
    end

    // 2 -> 1: bounded wait for in_ready, drain must take 2 cycles
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b0;
    cfg_valid = 1'b1; cfg_delay = 2'd1;
    @(negedge clk);
    cfg_valid = 1'b0;
    #1;
    n = 0;
    while (!in_ready && n < 10) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk("drain_len", 100, 16'(n), 16'd2);
    chk("sel_after_drain", 100, 16'(dl_sel), 16'd1);
    chk("busy_after_drain", 100, 16'(busy), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/shift8_ctrl.md
# shift8_ctrl

Controller and sequencer for the 8-bit four-tap delay line: three chained 8-bit DFF stages with a 2-bit tap select, where tap 0 is the input itself. It owns the delay-line input, the tap select, and a valid shadow pipeline. It turns the free-running datapath into a valid/ready stream stage with a programmable delay of 0–3 cycles. Delay changes are applied by draining in-flight samples first, so no sample is dropped or duplicated.

## Interface
- DATA_W, 8: sample width; must match the delay-line width.
- clk  in  1  clock for the block and the delay line
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input sample valid
- in_data  in  DATA_W  input sample
- in_ready  out  1  input accepted when in_valid & in_ready
- cfg_valid  in  1  delay-change request
- cfg_delay  in  2  requested delay, 0–3 cycles
- cfg_ready  out  1  request accepted when cfg_valid & cfg_ready
- dl_d  out  DATA_W  delay-line input; equals in_data
- dl_sel  out  2  delay-line tap select
- dl_q  in  DATA_W  delay-line selected tap output
- out_valid  out  1  out_data holds a real sample
- out_data  out  DATA_W  equals dl_q
- busy  out  1  high in DRAIN
- stall_cnt  out  16  present only with SHIFT8_CTRL_STALL_CNT_EN

## Operation
- Two FSM states: RUN and DRAIN. Reset state is RUN.
- **RUN**
  - in_ready=1, cfg_ready=1.
  - Shadow valid bits v[0..2] shift every cycle: v[0]<=in_valid&in_ready, v[i]<=v[i-1].
  - Delay-line stages have no enable and shift every cycle. Only the shadow qualifies the data.
- **out_valid**
  - dl_sel=0: out_valid = in_valid & in_ready (combinational path).
  - dl_sel=D>0: out_valid = v[D-1].
- **Delay change**
  - cfg accepted in RUN: latch new_delay and load drain_cnt = current dl_sel.
  - If drain_cnt=0: go to RUN; dl_sel=new_delay from the next cycle.
  - Otherwise: go to DRAIN.
- **DRAIN**
  - in_ready=0, cfg_ready=0, dl_sel holds the old value.
  - drain_cnt decrements each cycle; at 1 → RUN with dl_sel=new_delay.
  - DRAIN lasts exactly old_delay cycles.
- **Simultaneous events**
  - Input and cfg accepted in the same RUN cycle: the sample travels under the old delay and emerges during DRAIN.
  - cfg_delay equal to the current delay still drains, for uniform behaviour.
- **Reset mid-operation**: all shadow bits clear, state=RUN, dl_sel=0, pending cfg discarded. Delay-line data is not reset and is masked by the shadow.
- **Reset values**: in_ready=1, cfg_ready=1, out_valid=0 (in_valid & in_ready while dl_sel=0), dl_sel=0, busy=0, stall_cnt=0.

## Timing
- Sample accepted at cycle t with delay D appears with out_valid at cycle t+D. D=0 is same-cycle.
- cfg accepted at t with old delay Dₒ:
  - DRAIN occupies t+1..t+Dₒ.
  - New dl_sel and in_ready=1 take effect at t+Dₒ+1.
- Throughput in RUN is one sample per cycle with no bubbles.

## Configuration
- SHIFT8_CTRL_STALL_CNT_EN
  - Defined: stall_cnt counts cycles with in_valid=1 & in_ready=0. It saturates at 16'hFFFF and is cleared by rst.
  - Undefined: the stall_cnt port and its counter are absent. All other behaviour is identical.

## Structure
- **shift8_pkg**
  - DATA_W default, DELAY_W=2.
  - State enum: RUN, DRAIN.
  - STALL_CNT_W=16.
- **shift8_valid_track**
  - Sub-module: 3-bit valid shadow with inputs push and sel, output valid_at_tap.
  - shift8_ctrl holds the FSM, cfg latch, drain counter and optional stall counter.
- The delay line is instantiated beside shift8_ctrl by the parent, not inside it.

## Test plan
- Reset, then stream 0x01..0x08 back-to-back at delay 0 → out_data=in_data the same cycle, out_valid every cycle.
- cfg_delay=3 at delay 0 → no DRAIN, dl_sel=3 next cycle. Stream 0xA0..0xA3 from t → outputs at t+3..t+6, in order.
- At delay 3, cfg_delay=1 with simultaneous sample 0x5A at t → in_ready=0 and busy=1 for t+1..t+3, 0x5A out at t+3, dl_sel=1 from t+4.
- At delay 2, hold in_valid through a cfg change → no sample lost or duplicated; with macro defined, stall_cnt=2.
- Assert rst mid-DRAIN with samples in flight → next cycle out_valid=0, dl_sel=0, in_ready=1, stale dl_q never flagged valid.
- cfg_delay equal to the current delay of 2 → DRAIN lasts 2 cycles, dl_sel unchanged.
